// File: rtl/multichannel_input_buffer_pkg.sv
// Shared types and helpers for the multichannel input buffer.
package multichannel_input_buffer_pkg;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  // Width of a counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // LSB position of a lane inside the packed sink_data bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/multichannel_input_buffer_sample_ram.sv
// Simple dual-port sample store: one write port, one read port, registered read data.
module sample_ram
  import multichannel_input_buffer_pkg::*;
#(
  parameter int WIDTH = 14,
  parameter int DEPTH = 2048
) (
  input  logic                          i_clk,
  input  logic                          i_we,
  input  logic [clog2_min1(DEPTH)-1:0]  i_waddr,
  input  logic [WIDTH-1:0]              i_wdata,
  input  logic [clog2_min1(DEPTH)-1:0]  i_raddr,
  output logic [WIDTH-1:0]              o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/multichannel_input_buffer.sv
// Captures one batch per ADC lane, then replays each lane as an Avalon-ST packet.
//   state | meaning
//   IDLE  | waiting for enable; sink traffic ignored
//   FILL  | writing every lane at wr_idx on each sink_valid
//   DRAIN | replaying ch0..chN-1 packets; sink traffic flagged as dropped
//   DONE  | RUNS batches replayed; parked until reset
module multichannel_input_buffer
  import multichannel_input_buffer_pkg::*;
#(
  parameter int DATA_WIDTH   = 14,
  parameter int NUM_CHANNELS = 4,
  parameter int BATCH_SIZE   = 2048,
  parameter int RUNS         = 3
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_enable,
  input  logic                                     i_sink_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]       i_sink_data,
  input  logic                                     i_source_ready,
  output logic                                     o_source_valid,
  output logic                                     o_source_sop,
  output logic                                     o_source_eop,
  output logic [clog2_min1(NUM_CHANNELS)-1:0]      o_source_channel,
  output logic [DATA_WIDTH-1:0]                    o_source_data,
  output logic                                     o_busy,
  output logic                                     o_done,
  output logic                                     o_dropped
);

  localparam int CW = clog2_min1(NUM_CHANNELS);
  localparam int IW = clog2_min1(BATCH_SIZE);
  localparam int RW = clog2_min1(RUNS + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(BATCH_SIZE - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CHANNELS - 1);
  localparam logic [RW-1:0] RUNS_L   = RW'(RUNS);

  state_t                r_state;
  logic [IW-1:0]         r_wr_idx, r_rd_idx, r_s1_idx;
  logic [CW-1:0]         r_rd_ch, r_s1_ch, r_ch;
  logic [RW-1:0]         r_run_cnt;
  logic                  r_issue_pend, r_s1_valid;
  logic                  r_valid, r_sop, r_eop, r_busy, r_done, r_dropped;
  logic [DATA_WIDTH-1:0] r_data;

  logic [DATA_WIDTH-1:0] w_lane_rdata [NUM_CHANNELS];
  logic                  w_we, w_xfer, w_out_load, w_s1_adv, w_issue, w_last_xfer;
  logic [IW-1:0]         w_raddr;
  logic [RW-1:0]         w_run_next;

  // Stage 1 is the RAM output register; while it cannot advance, its own index is
  // re-read so the RAM keeps presenting the same sample through a stall.
  assign w_we        = (r_state == FILL) && i_sink_valid;
  assign w_xfer      = r_valid && i_source_ready;
  assign w_out_load  = r_s1_valid && (!r_valid || i_source_ready);
  assign w_s1_adv    = !r_s1_valid || w_out_load;
  assign w_issue     = (r_state == DRAIN) && r_issue_pend && w_s1_adv;
  assign w_raddr     = w_issue ? r_rd_idx : r_s1_idx;
  assign w_last_xfer = w_xfer && r_eop && (r_ch == CH_LAST);
  assign w_run_next  = r_run_cnt + RW'(1);

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    sample_ram #(.WIDTH(DATA_WIDTH), .DEPTH(BATCH_SIZE)) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (r_wr_idx),
      .i_wdata (i_sink_data[lane_lsb(k, DATA_WIDTH) +: DATA_WIDTH]),
      .i_raddr (w_raddr),
      .o_rdata (w_lane_rdata[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_rd_ch      <= '0;
      r_s1_idx     <= '0;
      r_s1_ch      <= '0;
      r_s1_valid   <= 1'b0;
      r_issue_pend <= 1'b0;
      r_run_cnt    <= '0;
      r_valid      <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
      r_ch         <= '0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_dropped    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_s1_valid <= 1'b1;
        r_s1_idx   <= r_rd_idx;
        r_s1_ch    <= r_rd_ch;
        r_rd_idx   <= r_rd_idx + IW'(1);
        if (r_rd_idx == IDX_LAST) begin
          if (r_rd_ch == CH_LAST) begin
            r_rd_ch      <= '0;
            r_issue_pend <= 1'b0;
          end else begin
            r_rd_ch <= r_rd_ch + CW'(1);
          end
        end
      end else if (w_out_load) begin
        r_s1_valid <= 1'b0;
      end

      if (w_out_load) begin
        r_valid <= 1'b1;
        r_data  <= w_lane_rdata[r_s1_ch];
        r_sop   <= (r_s1_idx == '0);
        r_eop   <= (r_s1_idx == IDX_LAST);
        r_ch    <= r_s1_ch;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      if ((r_state == DRAIN) && i_sink_valid) r_dropped <= 1'b1;

      case (r_state)
        IDLE: begin
          if (i_enable) begin
            r_state <= FILL;
            r_busy  <= 1'b1;
          end
        end
        FILL: begin
          if (i_sink_valid) begin
            r_wr_idx <= r_wr_idx + IW'(1);
            if (r_wr_idx == IDX_LAST) begin
              r_state      <= DRAIN;
              r_issue_pend <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (w_last_xfer) begin
            r_run_cnt <= w_run_next;
            if ((RUNS != 0) && (w_run_next == RUNS_L)) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if (i_enable) begin
              r_state <= FILL;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      endcase
    end
  end

  assign o_source_valid   = r_valid;
  assign o_source_sop     = r_sop;
  assign o_source_eop     = r_eop;
  assign o_source_channel = r_ch;
  assign o_source_data    = r_data;
  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_dropped        = r_dropped;

endmodule
